dram_cmd_scheduler: RTL and testbench

//  Single-bank DRAM command generator. Sits directly upstream of the DRAM

---
 rtl/dram_pkg.sv | 30 +++
 rtl/dram_timing_ctr.sv | 26 ++
 rtl/dram_cmd_scheduler.sv | 177 +++++++++++++++++
 tb/tb_dram_cmd_scheduler.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// Shared DRAM command encodings, default timings and scheduler states.
// The timing checker and the command scheduler both import this package.
package dram_pkg;

   typedef enum logic [1:0] {
      ACT   = 2'b00,
      READ  = 2'b01,
      WRITE = 2'b10,
      PRE   = 2'b11
   } cmd_e;

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      ACT_WAIT = 2'b01,
      OPEN     = 2'b10,
      PRE_WAIT = 2'b11
   } sched_state_e;

   localparam int unsigned ROW_W_DEF        = 14;
   localparam int unsigned T_RCD_DEF        = 3;
   localparam int unsigned T_RAS_DEF        = 7;
   localparam int unsigned T_RP_DEF         = 3;
   localparam int unsigned IDLE_TIMEOUT_DEF = 8;

   // Counter preload for a constraint t, given how many cycles the issue path adds.
   function automatic int unsigned wait_load(input int unsigned t, input int unsigned lead);
      return (t > lead) ? (t - lead) : 0;
   endfunction

endpackage

// File: rtl/dram_timing_ctr.sv
// Loadable down-counter that saturates at zero; done while the count is zero.
module dram_timing_ctr #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_val,
   output logic         o_done_c
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_val;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - W'(1);
      end
   end

   assign o_done_c = (r_cnt == '0);

endmodule

// File: rtl/dram_cmd_scheduler.sv
// Single-bank open-page DRAM command scheduler (ACT/READ/WRITE/PRE, tRCD/tRAS/tRP).
// Define DRAM_SCHED_IDLE_PRE_EN to auto-precharge a row idle for IDLE_TIMEOUT cycles.
module dram_cmd_scheduler
   import dram_pkg::*;
#(
   parameter int unsigned ROW_W = ROW_W_DEF,
   parameter int unsigned T_RCD = T_RCD_DEF,
   parameter int unsigned T_RAS = T_RAS_DEF,
   parameter int unsigned T_RP  = T_RP_DEF
`ifdef DRAM_SCHED_IDLE_PRE_EN
   ,
   parameter int unsigned IDLE_TIMEOUT = IDLE_TIMEOUT_DEF
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_write,
   input  logic [ROW_W-1:0] req_row,
   output logic             cmd_valid,
   output logic [1:0]       cmd,
   output logic [ROW_W-1:0] cmd_row,
   output logic             row_open,
   output logic [ROW_W-1:0] open_row
);

   localparam int unsigned T_MAX = (T_RAS > T_RCD) ? ((T_RAS > T_RP) ? T_RAS : T_RP)
                                                   : ((T_RCD > T_RP) ? T_RCD : T_RP);
   localparam int unsigned CTR_W = $clog2(T_MAX + 1);

   // tRAS is checked directly in OPEN (one cycle of issue latency); tRCD and tRP
   // also absorb the wait-state exit cycle, hence the larger lead.
   localparam logic [CTR_W-1:0] RCD_LD = CTR_W'(wait_load(T_RCD, 2));
   localparam logic [CTR_W-1:0] RAS_LD = CTR_W'(wait_load(T_RAS, 1));
   localparam logic [CTR_W-1:0] RP_LD  = CTR_W'(wait_load(T_RP, 2));

   sched_state_e     r_state;
   sched_state_e     w_state_nxt;
   logic             r_cmd_valid;
   cmd_e             r_cmd;
   logic [ROW_W-1:0] r_cmd_row;
   logic             r_row_open;
   logic [ROW_W-1:0] r_open_row;

   logic             w_fire;
   cmd_e             w_cmd_nxt;
   logic [ROW_W-1:0] w_row_nxt;
   logic             w_row_open_nxt;
   logic [ROW_W-1:0] w_open_row_nxt;
   logic             w_ld_rcd;
   logic             w_ld_ras;
   logic             w_ld_rp;
   logic             w_rcd_done;
   logic             w_ras_done;
   logic             w_rp_done;
   logic             w_hit;
   logic             w_idle_expired;

   dram_timing_ctr #(.W(CTR_W)) u_rcd (
      .clk(clk), .rst_n(rst_n), .i_load(w_ld_rcd), .i_val(RCD_LD), .o_done_c(w_rcd_done)
   );
   dram_timing_ctr #(.W(CTR_W)) u_ras (
      .clk(clk), .rst_n(rst_n), .i_load(w_ld_ras), .i_val(RAS_LD), .o_done_c(w_ras_done)
   );
   dram_timing_ctr #(.W(CTR_W)) u_rp (
      .clk(clk), .rst_n(rst_n), .i_load(w_ld_rp), .i_val(RP_LD), .o_done_c(w_rp_done)
   );

`ifdef DRAM_SCHED_IDLE_PRE_EN
   localparam int unsigned IDLE_W = $clog2(IDLE_TIMEOUT + 1);

   logic [IDLE_W-1:0] r_idle_cnt;

   // Counts consecutive request-free cycles while a row is open.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idle_cnt <= '0;
      end else if ((r_state != OPEN) || req_valid) begin
         r_idle_cnt <= '0;
      end else if (!w_idle_expired) begin
         r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
      end
   end

   assign w_idle_expired = (r_idle_cnt == IDLE_W'(IDLE_TIMEOUT));
`else
   assign w_idle_expired = 1'b0;
`endif

   assign w_hit = (req_row == r_open_row);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_fire         = 1'b0;
      w_cmd_nxt      = r_cmd;
      w_row_nxt      = r_cmd_row;
      w_row_open_nxt = r_row_open;
      w_open_row_nxt = r_open_row;
      w_ld_rcd       = 1'b0;
      w_ld_ras       = 1'b0;
      w_ld_rp        = 1'b0;
      req_ready      = 1'b0;
      case (r_state)
         IDLE: begin
            if (req_valid) begin
               w_fire         = 1'b1;
               w_cmd_nxt      = ACT;
               w_row_nxt      = req_row;
               w_row_open_nxt = 1'b1;
               w_open_row_nxt = req_row;
               w_ld_rcd       = 1'b1;
               w_ld_ras       = 1'b1;
               w_state_nxt    = ACT_WAIT;
            end
         end
         ACT_WAIT: begin
            if (w_rcd_done) begin
               w_state_nxt = OPEN;
            end
         end
         OPEN: begin
            if (req_valid && w_hit) begin
               w_fire    = 1'b1;
               w_cmd_nxt = req_write ? WRITE : READ;
               w_row_nxt = r_open_row;
               req_ready = 1'b1;
            end else if ((req_valid || w_idle_expired) && w_ras_done) begin
               w_fire         = 1'b1;
               w_cmd_nxt      = PRE;
               w_row_nxt      = r_open_row;
               w_row_open_nxt = 1'b0;
               w_ld_rp        = 1'b1;
               w_state_nxt    = PRE_WAIT;
            end
         end
         PRE_WAIT: begin
            if (w_rp_done) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Command and row-status registers; row status changes with the ACT/PRE it reflects.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cmd_valid <= 1'b0;
         r_cmd       <= PRE;
         r_cmd_row   <= '0;
         r_row_open  <= 1'b0;
         r_open_row  <= '0;
      end else begin
         r_cmd_valid <= w_fire;
         r_cmd       <= w_cmd_nxt;
         r_cmd_row   <= w_row_nxt;
         r_row_open  <= w_row_open_nxt;
         r_open_row  <= w_open_row_nxt;
      end
   end

   assign cmd_valid = r_cmd_valid;
   assign cmd       = r_cmd;
   assign cmd_row   = r_cmd_row;
   assign row_open  = r_row_open;
   assign open_row  = r_open_row;

endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// Directed + random bench for dram_cmd_scheduler with an expected-command queue
// and an independent tRCD/tRAS/tRP model watching the command stream.
module tb_dram_cmd_scheduler;
   import dram_pkg::*;

   localparam int unsigned ROW_W = 14;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             req_valid;
   logic             req_ready;
   logic             req_write;
   logic [ROW_W-1:0] req_row;
   logic             cmd_valid;
   logic [1:0]       cmd;
   logic [ROW_W-1:0] cmd_row;
   logic             row_open;
   logic [ROW_W-1:0] open_row;

   dram_cmd_scheduler dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_row(req_row),
      .cmd_valid(cmd_valid), .cmd(cmd), .cmd_row(cmd_row),
      .row_open(row_open), .open_row(open_row)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [1:0]       cmd;
      logic [ROW_W-1:0] row;
      int               cyc;
   } exp_t;

   exp_t             q[$];
   exp_t             mon_e;
   int               total   = 0;
   int               bad     = 0;
   int               acc_cnt = 0;
   bit               exact   = 1'b1;
   bit               m_open  = 1'b0;
   logic [ROW_W-1:0] m_row   = '0;
   int               last_act = -1000;
   int               last_pre = -1000;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_ge(input string tag, input int obs, input int lim);
      total++;
      assert (obs >= lim) else begin
         bad++;
         $error("FAIL %s observed=%0d required>=%0d", tag, obs, lim);
      end
   endtask

   function automatic void push(input logic [1:0] c, input logic [ROW_W-1:0] r, input int cy);
      exp_t e;
      e.cmd = c;
      e.row = r;
      e.cyc = cy;
      q.push_back(e);
   endfunction

   // Monitor: protocol timing model plus scoreboard pop on each issued command.
   always @(negedge clk) begin
      if (!rst_n) begin
         m_open   = 1'b0;
         last_act = -1000;
         last_pre = -1000;
      end else begin
         if (req_ready) acc_cnt++;
         if (cmd_valid) begin
            if (cmd === ACT) begin
               check("act_row_closed", 32'(m_open), 32'd0);
               check_ge("trp", cyc, last_pre + 3);
               m_open   = 1'b1;
               m_row    = cmd_row;
               last_act = cyc;
            end else if (cmd === PRE) begin
               check("pre_row_open", 32'(m_open), 32'd1);
               check("pre_row", 32'(cmd_row), 32'(m_row));
               check_ge("tras", cyc, last_act + 7);
               m_open   = 1'b0;
               last_pre = cyc;
            end else begin
               check("rw_row_open", 32'(m_open), 32'd1);
               check("rw_row", 32'(cmd_row), 32'(m_row));
               check_ge("trcd", cyc, last_act + 3);
            end
            check("row_open_out", 32'(row_open), 32'(m_open));
            if (m_open) check("open_row_out", 32'(open_row), 32'(m_row));
            if (exact || cmd === READ || cmd === WRITE) begin
               total++;
               assert (q.size() > 0) else begin
                  bad++;
                  $error("FAIL unexpected_cmd observed=%0d expected=none cycle=%0d", cmd, cyc);
               end
               if (q.size() > 0) begin
                  mon_e = q.pop_front();
                  check("cmd_code", 32'(cmd), 32'(mon_e.cmd));
                  check("cmd_row", 32'(cmd_row), 32'(mon_e.row));
                  if (mon_e.cyc >= 0) check("cmd_cycle", 32'(cyc), 32'(mon_e.cyc));
               end
            end
         end
      end
   end

   task automatic apply_reset();
      req_valid = 1'b0;
      rst_n     = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic send_req(input logic wr, input logic [ROW_W-1:0] row);
      bit got;
      got       = 1'b0;
      req_valid = 1'b1;
      req_write = wr;
      req_row   = row;
      for (int k = 0; k < 60 && !got; k++) begin
         @(negedge clk);
         if (req_ready) got = 1'b1;
      end
      total++;
      assert (got) else begin
         bad++;
         $error("FAIL req_accept observed=0 expected=1 row=%0d", row);
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic wait_drain();
      for (int k = 0; k < 80 && q.size() != 0; k++) @(negedge clk);
      check("queue_drain", 32'(q.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, t, m, a0, g;
      logic [ROW_W-1:0] rows [4];
      logic [ROW_W-1:0] rr;
      logic             wr;
      rows[0] = 14'd2; rows[1] = 14'd5; rows[2] = 14'd9; rows[3] = 14'd13;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_row   = '0;
      rst_n     = 1'b1;
      #1 rst_n  = 1'b0;
      #1;
      check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
      check("rst_cmd", 32'(cmd), 32'd3);
      check("rst_cmd_row", 32'(cmd_row), 32'd0);
      check("rst_row_open", 32'(row_open), 32'd0);
      check("rst_open_row", 32'(open_row), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd0);

      // 1: cold read of row 5, then 2: three back-to-back hits
      apply_reset();
      n = cyc;
      push(ACT, 14'd5, n + 1);
      push(READ, 14'd5, n + 4);
      a0 = acc_cnt;
      send_req(1'b0, 14'd5);
      check("t1_row_open", 32'(row_open), 32'd1);
      check("t1_open_row", 32'(open_row), 32'd5);
      check("t1_ready_pulses", 32'(acc_cnt - a0), 32'd1);
      n = cyc;
      push(READ, 14'd5, n + 1);
      push(WRITE, 14'd5, n + 2);
      push(READ, 14'd5, n + 3);
      send_req(1'b0, 14'd5);
      send_req(1'b1, 14'd5);
      send_req(1'b0, 14'd5);
      wait_drain();

      // 3: miss presented 4 cycles after ACT
      apply_reset();
      n = cyc;
      t = n + 1;
      push(ACT, 14'd5, t);
      push(READ, 14'd5, t + 3);
      send_req(1'b0, 14'd5);
      @(posedge clk);
      #1;
      push(PRE, 14'd5, t + 7);
      push(ACT, 14'd9, t + 10);
      push(WRITE, 14'd9, t + 13);
      send_req(1'b1, 14'd9);
      wait_drain();

      // 4: reset while waiting for tRCD
      apply_reset();
      req_valid = 1'b1;
      req_write = 1'b0;
      req_row   = 14'd3;
      @(posedge clk);
      #1;
      check("t4_act_valid", 32'(cmd_valid), 32'd1);
      check("t4_act_code", 32'(cmd), 32'd0);
      rst_n = 1'b0;
      #1;
      check("t4_rst_cmd_valid", 32'(cmd_valid), 32'd0);
      check("t4_rst_cmd", 32'(cmd), 32'd3);
      check("t4_rst_cmd_row", 32'(cmd_row), 32'd0);
      check("t4_rst_row_open", 32'(row_open), 32'd0);
      check("t4_rst_open_row", 32'(open_row), 32'd0);
      check("t4_rst_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      m = cyc;
      push(ACT, 14'd3, m + 1);
      push(READ, 14'd3, m + 4);
      send_req(1'b0, 14'd3);
      wait_drain();

      // 5: idle auto-close (or none without the feature)
      apply_reset();
      n = cyc;
      t = n + 1;
      push(ACT, 14'd7, t);
      push(READ, 14'd7, t + 3);
`ifdef DRAM_SCHED_IDLE_PRE_EN
      push(PRE, 14'd7, t + 12);
`endif
      send_req(1'b0, 14'd7);
      while (cyc < t + 20) @(posedge clk);
      #1;
`ifdef DRAM_SCHED_IDLE_PRE_EN
      check("t5_row_open", 32'(row_open), 32'd0);
`else
      check("t5_row_open", 32'(row_open), 32'd1);
      check("t5_open_row", 32'(open_row), 32'd7);
`endif
      check("t5_queue", 32'(q.size()), 32'd0);

      // 6: random traffic over four rows
      apply_reset();
      exact = 1'b0;
      a0    = acc_cnt;
      for (int i = 0; i < 40; i++) begin
         rr = rows[$urandom_range(0, 3)];
         wr = 1'($urandom_range(0, 1));
         push(wr ? WRITE : READ, rr, -1);
         send_req(wr, rr);
         g = int'($urandom_range(0, 3));
         if (g > 0) begin
            repeat (g) @(posedge clk);
            #1;
         end
      end
      wait_drain();
      check("t6_accepts", 32'(acc_cnt - a0), 32'd40);
      exact = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
